mips_mc_ctrl: RTL and testbench
===============================

MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port opcode, input, 6 bits: instruction register bits [31:26].
REQ-004 SHALL have port funct, input, 6 bits: instruction register bits [5:0].
REQ-005 SHALL have port alu_zero_flag, input, 1 bit: ALU zero result, sampled in BRANCH.
REQ-006 SHALL have port alu_sel, output, `OP_SIZE bits: ALU operation select; ADD=010, SUB=110, AND=000, OR=001, SLT=111.
REQ-007 SHALL have port pc_en, output, 1 bit: PC load enable (unconditional write OR branch-taken).
REQ-008 SHALL have ports i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, each output, 1 bit: datapath strobes and mux selects.
REQ-009 SHALL have ports alu_src_b and pc_src, each output, 2 bits: B mux (0 reg, 1 const 4, 2 sign-ext imm, 3 sign-ext imm<<2) and PC mux (0 ALU, 1 ALUOut, 2 jump target).
REQ-010 SHALL have port illegal_op, output, 1 bit: one-cycle pulse on an unrecognised opcode/funct.

Function
REQ-011 SHALL be a Moore FSM; all outputs SHALL decode from the current state only (plus alu_zero_flag for pc_en), with no output registers.
REQ-012 SHALL implement states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, BRANCH, JUMP.
REQ-013 FETCH SHALL assert mem_read, ir_write, pc_en (pc_src=0), alu_src_a=0, alu_src_b=1, alu_sel=ADD; next state DECODE.
REQ-014 DECODE SHALL drive alu_src_a=0, alu_src_b=3, alu_sel=ADD (branch target precompute) and branch on opcode: 100011/101011 -> MEM_ADDR, 000000 -> R_EXEC, 000100 -> BRANCH, 000010 -> JUMP.
REQ-015 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=2, alu_sel=ADD; next MEM_RD for lw, MEM_WR for sw.
REQ-016 MEM_RD SHALL assert mem_read, i_or_d -> MEM_WB; MEM_WB SHALL assert reg_write, mem_to_reg, reg_dst=0 -> FETCH; MEM_WR SHALL assert mem_write, i_or_d -> FETCH.
REQ-017 R_EXEC SHALL drive alu_src_a=1, alu_src_b=0, and alu_sel from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT; next R_WB.
REQ-018 R_WB SHALL assert reg_write, reg_dst=1, mem_to_reg=0 -> FETCH.
REQ-019 BRANCH SHALL drive alu_src_a=1, alu_src_b=0, alu_sel=SUB, pc_src=1, pc_en=alu_zero_flag (same cycle) -> FETCH.
REQ-020 JUMP SHALL assert pc_en with pc_src=2 -> FETCH.
REQ-021 An unrecognised opcode in DECODE, or unrecognised funct in R_EXEC, SHALL pulse illegal_op for that cycle, suppress all writes, and return to FETCH.
REQ-022 Instruction latency SHALL be: lw 5, sw 4, R-type 4, beq 3, j 3 cycles including FETCH.
REQ-023 In states not listed as driving a given strobe, that strobe SHALL be 0; unused selects SHALL be 0 and alu_sel SHALL default to ADD.

Reset
REQ-024 rst high SHALL force state FETCH immediately (asynchronously), regardless of current state, including mid-instruction.
REQ-025 While rst is high all write strobes (pc_en, ir_write, reg_write, mem_write) and illegal_op SHALL be 0; the first FETCH actions occur on the first rising clk after rst deasserts.

Configuration
REQ-026 Macro MC_CTRL_IMM_EN, when defined, SHALL add states IMM_EXEC and IMM_WB supporting addi (001000, alu_sel ADD) and ori (001101, alu_sel OR), alu_src_a=1, alu_src_b=2, write-back with reg_dst=0, reg_write=1, latency 4.
REQ-027 Without MC_CTRL_IMM_EN, opcodes 001000 and 001101 SHALL be treated as illegal per REQ-021.

Structure
REQ-028 Shared defines file SHALL hold `WORD_SIZE (32), `OP_SIZE (3), ALU op codes `ADD/`SUB/`AND/`OR/`SLT, opcode and funct constants; state encodings SHALL be local.
REQ-029 The funct-to-alu_sel decode SHALL be a sub-module alu_op_dec (combinational), reusable by a future pipelined core.

Verification
REQ-030 Reset mid-MEM_RD: assert rst -> state FETCH within same cycle, all strobes 0; release -> FETCH strobes next edge.
REQ-031 lw (opcode 100011): sequence FETCH,DECODE,MEM_ADDR,MEM_RD,MEM_WB; reg_write=1, mem_to_reg=1 only in cycle 5.
REQ-032 R-type funct 100010: alu_sel=110 in R_EXEC; reg_write=1, reg_dst=1 next cycle; back to FETCH in cycle 5.
REQ-033 beq with alu_zero_flag=1 -> pc_en=1, pc_src=1 in BRANCH; with alu_zero_flag=0 -> pc_en=0.
REQ-034 opcode 111111 -> illegal_op=1 for exactly one cycle in DECODE, no write strobe, next state FETCH.
REQ-035 addi 001000 with MC_CTRL_IMM_EN -> alu_sel=010, reg_write in cycle 4; without macro -> illegal_op pulse.

Source files
------------

// File: rtl/mips_mc_ctrl_pkg.sv
// Shared widths, ALU op codes and instruction field constants for the multi-cycle MIPS controller.
// Optional immediate-ALU support (addi/ori) is enabled by defining MC_CTRL_IMM_EN.
`ifndef MIPS_MC_CTRL_DEFINES
`define MIPS_MC_CTRL_DEFINES
`define WORD_SIZE 32
`define OP_SIZE 3
`define ADD 3'b010
`define SUB 3'b110
`define AND 3'b000
`define OR  3'b001
`define SLT 3'b111
`endif

package mips_mc_ctrl_pkg;

    localparam int unsigned OPC_W   = 6;
    localparam int unsigned FUNCT_W = 6;

    // Opcode field values
    localparam logic [OPC_W-1:0] OPC_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OPC_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OPC_SW    = 6'b101011;
    localparam logic [OPC_W-1:0] OPC_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OPC_J     = 6'b000010;
    localparam logic [OPC_W-1:0] OPC_ADDI  = 6'b001000;
    localparam logic [OPC_W-1:0] OPC_ORI   = 6'b001101;

    // R-type funct field values
    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/alu_op_dec.sv
// Combinational R-type funct to ALU operation decode; flags functs it does not recognise.
module alu_op_dec
    import mips_mc_ctrl_pkg::*;
(
    input  logic [FUNCT_W-1:0]  funct,
    output logic [`OP_SIZE-1:0] alu_sel_c,
    output logic                funct_ok_c
);

    always_comb begin
        alu_sel_c  = `ADD;
        funct_ok_c = 1'b1;
        case (funct)
            FUNCT_ADD: alu_sel_c = `ADD;
            FUNCT_SUB: alu_sel_c = `SUB;
            FUNCT_AND: alu_sel_c = `AND;
            FUNCT_OR:  alu_sel_c = `OR;
            FUNCT_SLT: alu_sel_c = `SLT;
            default:   funct_ok_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: Moore FSM decoding datapath strobes from the current state.
// Define MC_CTRL_IMM_EN to add the IMM_EXEC/IMM_WB path for addi and ori.
module mips_mc_ctrl
    import mips_mc_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [OPC_W-1:0]    opcode,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                alu_zero_flag,
    output logic [`OP_SIZE-1:0] alu_sel,
    output logic                pc_en,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          pc_src,
    output logic                illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_R_EXEC,
        S_R_WB,
        S_BRANCH,
        S_JUMP
`ifdef MC_CTRL_IMM_EN
        , S_IMM_EXEC
        , S_IMM_WB
`endif
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [`OP_SIZE-1:0] r_alu_sel;
    logic                r_funct_ok;

    alu_op_dec u_alu_op_dec (
        .funct      (funct),
        .alu_sel_c  (r_alu_sel),
        .funct_ok_c (r_funct_ok)
    );

    // State register; reset lands in FETCH immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    // Next state and outputs; everything held at defaults while rst is high
    always_comb begin
        state_nxt  = S_FETCH;
        alu_sel    = `ADD;
        pc_en      = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        pc_src     = 2'd0;
        illegal_op = 1'b0;

        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    ir_write  = 1'b1;
                    pc_en     = 1'b1;
                    alu_src_b = 2'd1;
                    state_nxt = S_DECODE;
                end
                S_DECODE: begin
                    // Branch target precompute: PC + (imm << 2)
                    alu_src_b = 2'd3;
                    case (opcode)
                        OPC_LW, OPC_SW: state_nxt = S_MEM_ADDR;
                        OPC_RTYPE:      state_nxt = S_R_EXEC;
                        OPC_BEQ:        state_nxt = S_BRANCH;
                        OPC_J:          state_nxt = S_JUMP;
`ifdef MC_CTRL_IMM_EN
                        OPC_ADDI, OPC_ORI: state_nxt = S_IMM_EXEC;
`endif
                        default: begin
                            illegal_op = 1'b1;
                            state_nxt  = S_FETCH;
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                    state_nxt = (opcode == OPC_SW) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    mem_read  = 1'b1;
                    i_or_d    = 1'b1;
                    state_nxt = S_MEM_WB;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    state_nxt  = S_FETCH;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    state_nxt = S_FETCH;
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_sel   = r_alu_sel;
                    if (r_funct_ok) begin
                        state_nxt = S_R_WB;
                    end else begin
                        illegal_op = 1'b1;
                        state_nxt  = S_FETCH;
                    end
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    state_nxt = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_sel   = `SUB;
                    pc_src    = 2'd1;
                    pc_en     = alu_zero_flag;
                    state_nxt = S_FETCH;
                end
                S_JUMP: begin
                    pc_en     = 1'b1;
                    pc_src    = 2'd2;
                    state_nxt = S_FETCH;
                end
`ifdef MC_CTRL_IMM_EN
                S_IMM_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                    alu_sel   = (opcode == OPC_ORI) ? `OR : `ADD;
                    state_nxt = S_IMM_WB;
                end
                S_IMM_WB: begin
                    reg_write = 1'b1;
                    state_nxt = S_FETCH;
                end
`endif
                default: state_nxt = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed-vector bench for mips_mc_ctrl: every control output is packed and compared per cycle.
module tb_mips_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_zero_flag;
    logic [2:0] alu_sel;
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, pc_src;

    int n_vec = 0;
    int n_err = 0;

    logic [16:0] outs;
    logic [16:0] exp_seq [8];

    always #5 clk = ~clk;

    mips_mc_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .funct         (funct),
        .alu_zero_flag (alu_zero_flag),
        .alu_sel       (alu_sel),
        .pc_en         (pc_en),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_src        (pc_src),
        .illegal_op    (illegal_op)
    );

    assign outs = {alu_sel, pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                   reg_dst, reg_write, alu_src_a, alu_src_b, pc_src, illegal_op};

    function automatic logic [16:0] ev(input logic [2:0] a, input logic pe, input logic iod,
                                       input logic mr, input logic mw, input logic irw,
                                       input logic m2r, input logic rd, input logic rw,
                                       input logic asa, input logic [1:0] asb,
                                       input logic [1:0] ps, input logic ill);
        return {a, pe, iod, mr, mw, irw, m2r, rd, rw, asa, asb, ps, ill};
    endfunction

    localparam logic [2:0] A_ADD = 3'b010;
    localparam logic [2:0] A_SUB = 3'b110;

    //                                    alu    pe    iod   mr    mw    irw   m2r   rd    rw    asa   asb    ps     ill
    localparam logic [16:0] V_RST    = ev(A_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    localparam logic [16:0] V_FETCH  = ev(A_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0);
    localparam logic [16:0] V_DECODE = ev(A_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0);
    localparam logic [16:0] V_DEC_IL = ev(A_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 1'b1);
    localparam logic [16:0] V_MADDR  = ev(A_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 1'b0);
    localparam logic [16:0] V_MRD    = ev(A_ADD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    localparam logic [16:0] V_MWB    = ev(A_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
    localparam logic [16:0] V_MWR    = ev(A_ADD, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    localparam logic [16:0] V_RWB    = ev(A_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
    localparam logic [16:0] V_REX_IL = ev(A_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1);
    localparam logic [16:0] V_BR_T   = ev(A_SUB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0);
    localparam logic [16:0] V_BR_NT  = ev(A_SUB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0);
    localparam logic [16:0] V_JUMP   = ev(A_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0);
    localparam logic [16:0] V_IMMWB  = ev(A_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %05h expected %05h", tag, obs, exp);
        end
    endtask

    // Walk n cycles from FETCH against exp_seq, then confirm the FSM is back in FETCH
    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            chk($sformatf("%s.c%0d", tag, i + 1), outs, exp_seq[i]);
            @(negedge clk);
        end
        #1;
        chk($sformatf("%s.ret", tag), outs, V_FETCH);
    endtask

    initial begin
        logic [5:0] fl [5];
        logic [2:0] al [5];
        fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        al = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

        rst = 1'b1;
        opcode = 6'b000000;
        funct = 6'b100000;
        alu_zero_flag = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset", outs, V_RST);
        rst = 1'b0;
        #1;
        chk("post_reset_fetch", outs, V_FETCH);

        // lw: 5 cycles
        opcode = 6'b100011;
        exp_seq[0] = V_FETCH; exp_seq[1] = V_DECODE; exp_seq[2] = V_MADDR;
        exp_seq[3] = V_MRD;   exp_seq[4] = V_MWB;
        run("lw", 5);

        // sw: 4 cycles
        opcode = 6'b101011;
        exp_seq[3] = V_MWR;
        run("sw", 4);

        // R-type, each funct: 4 cycles
        opcode = 6'b000000;
        for (int k = 0; k < 5; k++) begin
            funct = fl[k];
            exp_seq[0] = V_FETCH; exp_seq[1] = V_DECODE;
            exp_seq[2] = ev(al[k], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0);
            exp_seq[3] = V_RWB;
            run($sformatf("rtype_%02h", fl[k]), 4);
        end

        // R-type with unknown funct: illegal pulse in R_EXEC, no writes
        funct = 6'b111111;
        exp_seq[2] = V_REX_IL;
        run("rtype_bad_funct", 3);

        // beq taken / not taken: 3 cycles
        opcode = 6'b000100;
        alu_zero_flag = 1'b1;
        exp_seq[2] = V_BR_T;
        run("beq_taken", 3);
        alu_zero_flag = 1'b0;
        exp_seq[2] = V_BR_NT;
        run("beq_not_taken", 3);

        // j: 3 cycles
        opcode = 6'b000010;
        exp_seq[2] = V_JUMP;
        run("jump", 3);

        // Unknown opcode: single illegal cycle in DECODE
        opcode = 6'b111111;
        exp_seq[1] = V_DEC_IL;
        run("illegal_opc", 2);

`ifdef MC_CTRL_IMM_EN
        opcode = 6'b001000;
        exp_seq[1] = V_DECODE;
        exp_seq[2] = ev(3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 1'b0);
        exp_seq[3] = V_IMMWB;
        run("addi", 4);
        opcode = 6'b001101;
        exp_seq[2] = ev(3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 1'b0);
        run("ori", 4);
`else
        opcode = 6'b001000;
        exp_seq[1] = V_DEC_IL;
        run("addi_illegal", 2);
        opcode = 6'b001101;
        run("ori_illegal", 2);
`endif

        // Reset asserted mid-MEM_RD of a lw
        opcode = 6'b100011;
        exp_seq[0] = V_FETCH; exp_seq[1] = V_DECODE; exp_seq[2] = V_MADDR;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("lw_rst.c%0d", i + 1), outs, exp_seq[i]);
            @(negedge clk);
        end
        #1;
        chk("lw_rst.memrd", outs, V_MRD);
        #1;
        rst = 1'b1;
        #1;
        chk("lw_rst.async", outs, V_RST);
        @(negedge clk);
        #1;
        chk("lw_rst.held", outs, V_RST);
        rst = 1'b0;
        #1;
        chk("lw_rst.fetch", outs, V_FETCH);
        @(negedge clk);
        #1;
        chk("lw_rst.decode", outs, V_DECODE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
